alu_sequencer: RTL

Sequencing controller in front of the 8-bit accumulator ALU. Owns the architectural accumulator and the Z/C/N/V flag register, accepts one operation at a time over a valid/ready request channel, drives the combinational ALU, registers results and returns them over a valid/ready response channel. Also sequences multi-pass operations, namely an iterative multiply, by reusing the ALU's add and shift paths over several cycles.

---
 rtl/alu_sequencer.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer: sequencing controller in front of the 8-bit accumulator ALU.
// Owns acc and {z,c,n,v} flags. Runs one op per request (valid/ready in),
// drives the external ALU, returns the result (valid/ready out).
// Ports: clk, rst_n; req_valid/req_ready/req_op/req_operand;
//        resp_valid/resp_ready/resp_acc/resp_flags/resp_err;
//        alu_type/alu_op/alu_acc/alu_reg out; alu_out/alu_c/alu_z/alu_n in.
// Optional macro ALU_SEQ_MUL_EN enables the iterative MUL (opcode 1100).
module alu_sequencer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [3:0] req_op,
    input  logic [7:0] req_operand,
    output logic       resp_valid,
    input  logic       resp_ready,
    output logic [7:0] resp_acc,
    output logic [3:0] resp_flags,
    output logic       resp_err,
    output logic       alu_type,
    output logic [3:0] alu_op,
    output logic [7:0] alu_acc,
    output logic [7:0] alu_reg,
    input  logic [7:0] alu_out,
    input  logic       alu_c,
    input  logic       alu_z,
    input  logic       alu_n
);

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0011;
    localparam logic [3:0] OP_SHL = 4'b0100;
    localparam logic [3:0] OP_SHR = 4'b0101;
    localparam logic [3:0] OP_AND = 4'b0110;
    localparam logic [3:0] OP_OR  = 4'b0111;
    localparam logic [3:0] OP_XOR = 4'b1000;
    localparam logic [3:0] OP_CMP = 4'b1010;
    localparam logic [3:0] OP_MUL = 4'b1100;

`ifdef ALU_SEQ_MUL_EN
    typedef enum logic [2:0] {
        S_IDLE, S_EXEC, S_MUL_ADD, S_MUL_SHIFT, S_RESP
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE, S_EXEC, S_RESP
    } state_t;
`endif

    state_t     state_q, state_d;
    logic [7:0] acc_q, acc_d;
    logic [3:0] flags_q, flags_d;
    logic [3:0] op_q, op_d;
    logic [7:0] opr_q, opr_d;
    logic       err_q, err_d;
    logic [7:0] res;
`ifdef ALU_SEQ_MUL_EN
    logic [7:0] prod_q, prod_d;
    logic [7:0] mcand_q, mcand_d;
    logic [7:0] mplier_q, mplier_d;
`endif

    function automatic logic op_legal(input logic [3:0] op);
        case (op)
            OP_LDA, OP_ADD, OP_SUB, OP_SHL, OP_SHR,
            OP_AND, OP_OR, OP_XOR, OP_CMP: op_legal = 1'b1;
`ifdef ALU_SEQ_MUL_EN
            OP_MUL:                        op_legal = 1'b1;
`endif
            default:                       op_legal = 1'b0;
        endcase
    endfunction

    assign alu_type   = 1'b0;
    assign resp_acc   = acc_q;
    assign resp_flags = flags_q;
    assign resp_err   = err_q;

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        flags_d    = flags_q;
        op_d       = op_q;
        opr_d      = opr_q;
        err_d      = err_q;
        res        = 8'h00;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        alu_op     = 4'b0000;
        alu_acc    = 8'h00;
        alu_reg    = 8'h00;
`ifdef ALU_SEQ_MUL_EN
        prod_d     = prod_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    op_d  = req_op;
                    opr_d = req_operand;
                    err_d = 1'b0;
                    if (!op_legal(req_op)) begin
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end else if (req_op == OP_LDA) begin
                        acc_d   = req_operand;
                        state_d = S_RESP;
`ifdef ALU_SEQ_MUL_EN
                    end else if (req_op == OP_MUL) begin
                        prod_d   = 8'h00;
                        mcand_d  = acc_q;
                        mplier_d = req_operand;
                        state_d  = S_MUL_ADD;
`endif
                    end else begin
                        state_d = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                alu_op  = op_q;
                alu_acc = acc_q;
                alu_reg = opr_q;
                res     = alu_out;
                // The ALU barrel shifter only looks at the low bits.
                if ((op_q == OP_SHL || op_q == OP_SHR) && (|opr_q[7:3]))
                    res = 8'h00;
                if (op_q == OP_CMP) begin
                    flags_d[3] = alu_z;
                    flags_d[1] = alu_n;
                end else begin
                    acc_d      = res;
                    flags_d[3] = (res == 8'h00);
                    flags_d[1] = res[7];
                    flags_d[2] = 1'b0;
                    flags_d[0] = 1'b0;
                    if (op_q == OP_ADD) begin
                        flags_d[2] = alu_c;
                        flags_d[0] = (acc_q[7] == opr_q[7]) &&
                                     (res[7] != acc_q[7]);
                    end else if (op_q == OP_SUB) begin
                        flags_d[2] = alu_c;
                        flags_d[0] = (acc_q[7] != opr_q[7]) &&
                                     (res[7] != acc_q[7]);
                    end
                end
                state_d = S_RESP;
            end
`ifdef ALU_SEQ_MUL_EN
            S_MUL_ADD: begin
                alu_op  = OP_ADD;
                alu_acc = prod_q;
                alu_reg = mcand_q;
                if (mplier_q[0])
                    prod_d = alu_out;
                state_d = S_MUL_SHIFT;
            end
            S_MUL_SHIFT: begin
                alu_op   = OP_SHL;
                alu_acc  = mcand_q;
                alu_reg  = 8'd1;
                mcand_d  = alu_out;
                mplier_d = mplier_q >> 1;
                if (mplier_q[7:1] == 7'd0) begin
                    acc_d   = prod_q;
                    flags_d = {(prod_q == 8'h00), 1'b0, prod_q[7], 1'b0};
                    state_d = S_RESP;
                end else begin
                    state_d = S_MUL_ADD;
                end
            end
`endif
            S_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            acc_q    <= 8'h00;
            flags_q  <= 4'h0;
            op_q     <= 4'h0;
            opr_q    <= 8'h00;
            err_q    <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            prod_q   <= 8'h00;
            mcand_q  <= 8'h00;
            mplier_q <= 8'h00;
`endif
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            flags_q  <= flags_d;
            op_q     <= op_d;
            opr_q    <= opr_d;
            err_q    <= err_d;
`ifdef ALU_SEQ_MUL_EN
            prod_q   <= prod_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
`endif
        end
    end

endmodule
